// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// Holds the request-kind codes, the RV32I major opcodes (shared with the
// main control decoder), the immediate range limits and a small range helper.
package instr_encoder_pkg;

  // Request kinds on in_kind; 9..15 are illegal.
  localparam logic [3:0] KIND_LW     = 4'd0;
  localparam logic [3:0] KIND_SW     = 4'd1;
  localparam logic [3:0] KIND_RTYPE  = 4'd2;
  localparam logic [3:0] KIND_BRANCH = 4'd3;
  localparam logic [3:0] KIND_ITYPE  = 4'd4;
  localparam logic [3:0] KIND_JALR   = 4'd5;
  localparam logic [3:0] KIND_JAL    = 4'd6;
  localparam logic [3:0] KIND_LUI    = 4'd7;
  localparam logic [3:0] KIND_AUIPC  = 4'd8;

  // Major opcodes, instr[6:0].
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Immediate limits (signed byte offsets / shift amounts).
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int SHAMT_MIN = 0;
  localparam int SHAMT_MAX = 31;
  localparam int BR_MIN    = -4096;
  localparam int BR_MAX    = 4094;
  localparam int JAL_MIN   = -(1 << 20);
  localparam int JAL_MAX   = (1 << 20) - 2;

  // Loader FSM states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } encStateT;

  // Decoded instruction description presented to the field packer.
  typedef struct packed {
    logic [3:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm;
  } encReqT;

  // Signed inclusive range test on a two's complement immediate.
  function automatic logic inRange(input logic signed [31:0] v,
                                   input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational RV32I field packer.
// Ports:
//   req     - decoded description (kind, register fields, funct3/funct7b5, imm)
//   instr   - 32-bit machine word (don't-care when illegal)
//   illegal - request cannot be encoded (bad kind, immediate out of range,
//             misaligned branch/jump target, reserved branch funct3)
module instr_field_pack
  import instr_encoder_pkg::*;
(
  input  encReqT      req,
  output logic [31:0] instr,
  output logic        illegal
);

  logic isShift;

  // funct3 001/101 under OP-IMM are slli/srli/srai: 5-bit shamt, funct7 above.
  assign isShift = (req.funct3 == 3'b001) || (req.funct3 == 3'b101);

  always_comb begin
    instr   = '0;
    illegal = 1'b0;
    case (req.kind)
      KIND_LW: begin
        instr   = {req.imm[11:0], req.rs1, req.funct3, req.rd, OP_LOAD};
        illegal = !inRange(req.imm, IMM12_MIN, IMM12_MAX);
      end
      KIND_SW: begin
        instr   = {req.imm[11:5], req.rs2, req.rs1, req.funct3,
                   req.imm[4:0], OP_STORE};
        illegal = !inRange(req.imm, IMM12_MIN, IMM12_MAX);
      end
      KIND_RTYPE: begin
        instr = {1'b0, req.funct7b5, 5'b00000, req.rs2, req.rs1,
                 req.funct3, req.rd, OP_OP};
      end
      KIND_BRANCH: begin
        instr   = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                   req.imm[4:1], req.imm[11], OP_BRANCH};
        // 010/011 have no branch meaning in RV32I.
        illegal = req.imm[0] || !inRange(req.imm, BR_MIN, BR_MAX) ||
                  (req.funct3 == 3'b010) || (req.funct3 == 3'b011);
      end
      KIND_ITYPE: begin
        if (isShift) begin
          instr   = {1'b0, req.funct7b5, 5'b00000, req.imm[4:0], req.rs1,
                     req.funct3, req.rd, OP_IMM};
          illegal = !inRange(req.imm, SHAMT_MIN, SHAMT_MAX);
        end else begin
          instr   = {req.imm[11:0], req.rs1, req.funct3, req.rd, OP_IMM};
          illegal = !inRange(req.imm, IMM12_MIN, IMM12_MAX);
        end
      end
      KIND_JALR: begin
        instr   = {req.imm[11:0], req.rs1, 3'b000, req.rd, OP_JALR};
        illegal = !inRange(req.imm, IMM12_MIN, IMM12_MAX);
      end
      KIND_JAL: begin
        instr   = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                   req.rd, OP_JAL};
        illegal = req.imm[0] || !inRange(req.imm, JAL_MIN, JAL_MAX);
      end
      KIND_LUI: begin
        instr   = {req.imm[31:12], req.rd, OP_LUI};
        illegal = |req.imm[11:0];
      end
      KIND_AUIPC: begin
        instr   = {req.imm[31:12], req.rd, OP_AUIPC};
        illegal = |req.imm[11:0];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder for the program loader.
// Accepts decoded instruction descriptions over valid/ready, encodes them and
// streams the words out of a one-deep registered stage with word-aligned
// addresses starting at BASE_ADDR.
// Ports:
//   clk, reset              - clock, synchronous active-low reset
//   start                   - pulse: begin a load at BASE_ADDR (ignored in LOAD)
//   in_valid/in_ready       - request handshake
//   in_kind..in_imm,in_last - request fields; in_last ends the program
//   out_valid/out_ready     - encoded-word handshake
//   out_instr, out_addr     - encoded word and its address
//   busy, done, err         - state is LOAD / DONE / ERR
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int               ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  encStateT          state;
  logic              outValidQ;
  logic [31:0]       outInstrQ;
  logic [ADDR_W-1:0] addrQ;
  logic              lastPending;  // last word accepted, waiting for its handshake
  encReqT            req;
  logic [31:0]       packedInstr;
  logic              reqIllegal;
  logic              accept;
  logic              outHs;

  assign req = '{kind:     in_kind,
                 rd:       in_rd,
                 rs1:      in_rs1,
                 rs2:      in_rs2,
                 funct3:   in_funct3,
                 funct7b5: in_funct7b5,
                 imm:      in_imm};

  instr_field_pack uPack (
    .req     (req),
    .instr   (packedInstr),
    .illegal (reqIllegal)
  );

  // Once the last word is taken nothing more belongs to this program, so
  // further requests are held off until the word drains and we reach DONE.
  assign in_ready = (state == ST_LOAD) && !lastPending && (!outValidQ || out_ready);
  assign accept   = in_valid && in_ready;
  assign outHs    = outValidQ && out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      outValidQ   <= 1'b0;
      outInstrQ   <= '0;
      addrQ       <= BASE_ADDR;
      lastPending <= 1'b0;
    end else begin
      // The counter always names the word currently in the output stage.
      if (outHs) begin
        outValidQ <= 1'b0;
        addrQ     <= addrQ + ADDR_W'(4);
      end
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          // A word still draining after an error belongs to the aborted
          // program; a fresh load discards it so addresses restart cleanly.
          if (start) begin
            state       <= ST_LOAD;
            addrQ       <= BASE_ADDR;
            outValidQ   <= 1'b0;
            lastPending <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (reqIllegal) begin
              state <= ST_ERR;
            end else begin
              outValidQ   <= 1'b1;
              outInstrQ   <= packedInstr;
              lastPending <= in_last;
            end
          end
          if (lastPending && outHs) begin
            state       <= ST_DONE;
            lastPending <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = outValidQ;
  assign out_instr = outInstrQ;
  assign out_addr  = addrQ;
  assign busy      = (state == ST_LOAD);
  assign done      = (state == ST_DONE);
  assign err       = (state == ST_ERR);

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases from the block's
// behaviour list, then randomized requests against an arithmetic reference
// encoder with a queue of expected words and a model address counter.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic        in_funct7b5, in_last;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_addr;
  logic        busy, done, err;

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm),
    .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          nChecks = 0;
  int          nFail   = 0;
  logic        sValid, sReady, sBusy, sDone, sErr;
  logic [31:0] sInstr, sAddr;
  bit          accepted, lastIll, rndReady, prevStall;
  logic [31:0] prevInstr, prevAddr, lastHsInstr, lastHsAddr, modelAddr;
  int          hsCount = 0;
  logic [31:0] expQ[$];
  int          waited, hs0, n;
  logic [3:0]  rk;
  logic [2:0]  rf3;
  logic [31:0] rimm;
  logic        rlast;
  int          ri, sel;
  int          edges[16] = '{-2049, -2048, 2047, 2048, -1, 0, 31, 32,
                             -4096, 4094, 4095, -4098, 1048574, 1048576,
                             -1048576, -1048578};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned fld(input int unsigned v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 1);
  endfunction

  // Reference encoder: field placement by weighted sums, legality by plain
  // integer range tests on the sign-extended immediate.
  function automatic void refEncode(input logic [3:0] k, input logic [4:0] rd, rs1, rs2,
                                    input logic [2:0] f3, input logic f7,
                                    input logic [31:0] imm,
                                    output bit ill, output logic [31:0] w);
    longint      s;
    int unsigned u, d, a, b, f, t;
    s = longint'($signed(imm));
    u = imm; d = rd; a = rs1; b = rs2; f = f3; t = f7;
    ill = 0; w = 0;
    case (k)
      4'd0: begin
        ill = (s < -2048) || (s > 2047);
        w = 32'h03 + (d << 7) + (f << 12) + (a << 15) + (fld(u, 11, 0) << 20);
      end
      4'd1: begin
        ill = (s < -2048) || (s > 2047);
        w = 32'h23 + (fld(u, 4, 0) << 7) + (f << 12) + (a << 15) + (b << 20) +
            (fld(u, 11, 5) << 25);
      end
      4'd2: w = 32'h33 + (d << 7) + (f << 12) + (a << 15) + (b << 20) + (t << 30);
      4'd3: begin
        ill = (u % 2 != 0) || (s < -4096) || (s > 4094) || (f == 2) || (f == 3);
        w = 32'h63 + (fld(u, 11, 11) << 7) + (fld(u, 4, 1) << 8) + (f << 12) +
            (a << 15) + (b << 20) + (fld(u, 10, 5) << 25) + (fld(u, 12, 12) << 31);
      end
      4'd4: begin
        if (f == 1 || f == 5) begin
          ill = (s < 0) || (s > 31);
          w = 32'h13 + (d << 7) + (f << 12) + (a << 15) + (fld(u, 4, 0) << 20) + (t << 30);
        end else begin
          ill = (s < -2048) || (s > 2047);
          w = 32'h13 + (d << 7) + (f << 12) + (a << 15) + (fld(u, 11, 0) << 20);
        end
      end
      4'd5: begin
        ill = (s < -2048) || (s > 2047);
        w = 32'h67 + (d << 7) + (a << 15) + (fld(u, 11, 0) << 20);
      end
      4'd6: begin
        ill = (u % 2 != 0) || (s < -1048576) || (s > 1048574);
        w = 32'h6F + (d << 7) + (fld(u, 19, 12) << 12) + (fld(u, 11, 11) << 20) +
            (fld(u, 10, 1) << 21) + (fld(u, 20, 20) << 31);
      end
      4'd7: begin ill = (u % 4096 != 0); w = 32'h37 + (d << 7) + (u - u % 4096); end
      4'd8: begin ill = (u % 4096 != 0); w = 32'h17 + (d << 7) + (u - u % 4096); end
      default: ill = 1;
    endcase
  endfunction

  // One clock: sample and score at negedge, then return 1 time unit after
  // the posedge so the caller can drive the next cycle's inputs.
  task automatic cycle();
    @(negedge clk);
    sValid = out_valid; sReady = in_ready; sBusy = busy; sDone = done;
    sErr = err; sInstr = out_instr; sAddr = out_addr;
    accepted = in_valid && in_ready;
    if (reset) begin
      if (prevStall) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_instr", out_instr, prevInstr);
        chk("hold_addr", out_addr, prevAddr);
      end
      if (out_valid && out_ready) begin
        hsCount++;
        lastHsInstr = out_instr;
        lastHsAddr  = out_addr;
        chk("word_expected", {31'd0, expQ.size() != 0}, 32'd1);
        if (expQ.size() != 0) chk("instr", out_instr, expQ.pop_front());
        chk("addr", out_addr, modelAddr);
        modelAddr += 4;
      end
      prevStall = out_valid && !out_ready;
      prevInstr = out_instr;
      prevAddr  = out_addr;
    end else begin
      prevStall = 0;
    end
    @(posedge clk); #1;
    if (rndReady) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic doReset(input int cycles);
    reset = 0; in_valid = 0; start = 0;
    expQ.delete();
    modelAddr = BASE;
    repeat (cycles) cycle();
    reset = 1;
  endtask

  task automatic pulseStart();
    in_valid = 0;
    start = 1;
    modelAddr = BASE;
    cycle();
    start = 0;
  endtask

  // Present one request and hold it until accepted (bounded); in_valid stays
  // high on return so consecutive calls are back-to-back.
  task automatic sendReq(input logic [3:0] k, input logic [4:0] rd, rs1, rs2,
                         input logic [2:0] f3, input logic f7, input logic [31:0] imm,
                         input logic last, output int nWait);
    bit          ill;
    logic [31:0] w;
    in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3;
    in_funct7b5 = f7; in_imm = imm; in_last = last; in_valid = 1;
    nWait = 0;
    do begin
      cycle();
      if (!accepted) nWait++;
    end while (!accepted && nWait < 64);
    chk("accept", {31'd0, accepted}, 32'd1);
    lastIll = 0;
    if (accepted) begin
      refEncode(k, rd, rs1, rs2, f3, f7, imm, ill, w);
      lastIll = ill;
      if (!ill) expQ.push_back(w);
    end
  endtask

  initial begin
    reset = 0; start = 0; in_valid = 0; in_kind = 0; in_rd = 0; in_rs1 = 0;
    in_rs2 = 0; in_funct3 = 0; in_funct7b5 = 0; in_imm = 0; in_last = 0;
    out_ready = 1; rndReady = 0; prevStall = 0; modelAddr = BASE;
    lastHsInstr = 0; lastHsAddr = 0;

    // Reset state
    doReset(2);
    chk("rst_valid", {31'd0, sValid}, 32'd0);
    chk("rst_instr", sInstr, 32'd0);
    chk("rst_addr", sAddr, BASE);
    chk("rst_flags", {29'd0, sBusy, sDone, sErr}, 32'd0);

    pulseStart();
    cycle();
    chk("start_busy", {31'd0, sBusy}, 32'd1);
    chk("start_ready", {31'd0, sReady}, 32'd1);

    // lw x5, 8(x1): word visible one cycle after accept
    sendReq(4'd0, 5'd5, 5'd1, 5'd0, 3'b010, 1'b0, 32'd8, 1'b0, waited);
    in_valid = 0;
    cycle();
    chk("lw_latency", {31'd0, sValid}, 32'd1);
    chk("lw_instr", sInstr, 32'h0080A283);
    chk("lw_addr", lastHsAddr, 32'h0);

    // add then sub, back to back
    sendReq(4'd2, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0, 1'b0, waited);
    sendReq(4'd2, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0, 1'b0, waited);
    chk("b2b_no_wait", waited, 0);
    chk("add_instr", lastHsInstr, 32'h002081B3);
    chk("add_addr", lastHsAddr, 32'h4);
    in_valid = 0;
    cycle();
    chk("sub_instr", lastHsInstr, 32'h402081B3);
    chk("sub_addr", lastHsAddr, 32'h8);

    // beq, jal, lui(last)
    sendReq(4'd3, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, -32'sd4, 1'b0, waited);
    sendReq(4'd6, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd8, 1'b0, waited);
    chk("beq_instr", lastHsInstr, 32'hFE208EE3);
    sendReq(4'd7, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345000, 1'b1, waited);
    chk("jal_instr", lastHsInstr, 32'h008000EF);
    in_valid = 0;
    cycle();
    chk("lui_instr", lastHsInstr, 32'h12345137);
    cycle();
    chk("done_flag", {31'd0, sDone}, 32'd1);
    chk("done_busy", {31'd0, sBusy}, 32'd0);

    // Backpressure: three stalled cycles, then exactly one handshake
    pulseStart();
    out_ready = 0;
    sendReq(4'd4, 5'd4, 5'd4, 5'd0, 3'b000, 1'b0, -32'sd1, 1'b0, waited);
    in_valid = 0;
    hs0 = hsCount;
    repeat (3) begin
      cycle();
      chk("bp_in_ready", {31'd0, sReady}, 32'd0);
      chk("bp_valid", {31'd0, sValid}, 32'd1);
    end
    out_ready = 1;
    cycle();
    cycle();
    chk("bp_one_hs", hsCount - hs0, 1);
    chk("bp_addr", sAddr, BASE + 32'd4);

    // Out-of-range immediate -> ERR, no word
    sendReq(4'd4, 5'd1, 5'd1, 5'd0, 3'b000, 1'b0, 32'd4096, 1'b0, waited);
    in_valid = 0;
    cycle();
    chk("err_flag", {31'd0, sErr}, 32'd1);
    chk("err_no_word", {31'd0, sValid}, 32'd0);
    pulseStart();
    cycle();
    chk("restart_err", {31'd0, sErr}, 32'd0);
    chk("restart_busy", {31'd0, sBusy}, 32'd1);
    chk("restart_addr", sAddr, BASE);

    // Mid-load reset with a word pending
    sendReq(4'd0, 5'd6, 5'd2, 5'd0, 3'b010, 1'b0, 32'd12, 1'b0, waited);
    sendReq(4'd1, 5'd0, 5'd2, 5'd7, 3'b010, 1'b0, -32'sd20, 1'b0, waited);
    sendReq(4'd5, 5'd1, 5'd3, 5'd0, 3'b000, 1'b0, 32'd2047, 1'b0, waited);
    out_ready = 0;
    doReset(1);
    cycle();
    chk("mr_valid", {31'd0, sValid}, 32'd0);
    chk("mr_busy", {31'd0, sBusy}, 32'd0);
    chk("mr_addr", sAddr, BASE);
    out_ready = 1;

    // Randomized stream with random backpressure
    pulseStart();
    rndReady = 1;
    for (int i = 0; i < 400; i++) begin
      rk = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      rf3 = 3'($urandom);
      if (rk == 4'd3 && (rf3 == 3'd2 || rf3 == 3'd3) && $urandom_range(0, 7) != 0) rf3 = 3'd0;
      case (rk)
        4'd3: begin ri = (int'($urandom_range(0, 4095)) - 2048) * 2; rimm = ri; end
        4'd6: begin ri = (int'($urandom_range(0, 1048575)) - 524288) * 2; rimm = ri; end
        4'd7, 4'd8: rimm = $urandom & 32'hFFFFF000;
        4'd4: begin
          if (rf3 == 3'd1 || rf3 == 3'd5) ri = int'($urandom_range(0, 31));
          else ri = int'($urandom_range(0, 4095)) - 2048;
          rimm = ri;
        end
        default: begin ri = int'($urandom_range(0, 4095)) - 2048; rimm = ri; end
      endcase
      sel = $urandom_range(0, 15);
      if (sel == 0) rimm = $urandom;
      else if (sel == 1) rimm = edges[$urandom_range(0, 15)];
      rlast = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) begin in_valid = 0; cycle(); end
      sendReq(rk, 5'($urandom), 5'($urandom), 5'($urandom), rf3, 1'($urandom),
              rimm, rlast, waited);
      if (lastIll) begin
        in_valid = 0;
        cycle();
        chk("rnd_err", {31'd0, sErr}, 32'd1);
        n = 0;
        while (expQ.size() != 0 && n < 200) begin cycle(); n++; end
        chk("rnd_drain", expQ.size(), 0);
        pulseStart();
      end else if (rlast) begin
        in_valid = 0;
        n = 0;
        do begin cycle(); n++; end while (!sDone && n < 200);
        chk("rnd_done", {31'd0, sDone}, 32'd1);
        chk("rnd_done_q", expQ.size(), 0);
        pulseStart();
      end
    end
    in_valid = 0;
    rndReady = 0;
    out_ready = 1;
    repeat (3) cycle();
    chk("final_q", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
